serial_subtractor: RTL and testbench

- Digit-serial subtractor that inverts CAdder: given a (WIDTH+1)-bit sum and one WIDTH-bit operand a, it recovers the other operand, diff = sum - a.
- Processes DIGIT bits per cycle under a valid/ready handshake on both sides.
- Sits downstream of adder result streams to reconstruct operand b for self-checking datapaths and benches.

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: recovers diff = sum - a, DIGIT bits per cycle.
// Optional SERIAL_SUB_ERRCNT_EN adds a saturating borrow/overflow result counter.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
`ifdef SERIAL_SUB_ERRCNT_EN
  ,
  input  logic             err_clr,
  output logic [15:0]      err_cnt
`endif
);

  localparam int W1   = WIDTH + 1;
  localparam int NDIG = (W1 + DIGIT - 1) / DIGIT;
  localparam int PW   = NDIG * DIGIT;
  localparam int DW   = DIGIT + 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] sum_q;
  logic [PW-1:0] a_q;
  logic [PW-1:0] res_q;
  logic [PW-1:0] res_nx;
  logic [PW-1:0] dext;
  logic [CW-1:0] cnt_q;
  logic          br_q;
  logic [DW-1:0] dsub;
  logic          last;
  logic          accept;

  // Operands shift right so the active digit is always at bit 0.
  always_comb begin
    dsub = {1'b0, sum_q[DIGIT-1:0]}
         - {1'b0, a_q[DIGIT-1:0]}
         - DW'(br_q);
    dext = '0;
    dext[DIGIT-1:0] = dsub[DIGIT-1:0];
    res_nx = res_q | (dext << (DIGIT * int'(cnt_q)));
  end

  assign last   = (cnt_q == CW'(NDIG - 1));
  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      a_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      sum_q <= PW'(sum);
      a_q   <= PW'(a);
      res_q <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
    end else if (state_q == CALC) begin
      sum_q <= sum_q >> DIGIT;
      a_q   <= a_q >> DIGIT;
      res_q <= res_nx;
      cnt_q <= cnt_q + CW'(1);
      br_q  <= dsub[DIGIT];
      if (last) begin
        diff   <= res_nx[WIDTH-1:0];
        borrow <= dsub[DIGIT];
        ovf    <= res_nx[WIDTH] & ~dsub[DIGIT];
      end
    end
  end

`ifdef SERIAL_SUB_ERRCNT_EN
  // Clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (state_q == DONE && out_ready
                 && (borrow || ovf)
                 && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at DIGIT = 4, 1 and 17.
// Instances run in lockstep on shared operands.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        b;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [16:0] sum = '0;
  logic [15:0] a = '0;

  logic        in_ready  [3];
  logic        out_valid [3];
  logic        borrow    [3];
  logic        ovf       [3];
  logic [15:0] diff      [3];

`ifdef SERIAL_SUB_ERRCNT_EN
  logic        err_clr = 1'b0;
  logic [15:0] err_cnt [3];
`endif

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .sum(sum), .a(a),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .diff(diff[0]), .borrow(borrow[0]), .ovf(ovf[0])
`ifdef SERIAL_SUB_ERRCNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt[0])
`endif
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .sum(sum), .a(a),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .diff(diff[1]), .borrow(borrow[1]), .ovf(ovf[1])
`ifdef SERIAL_SUB_ERRCNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt[1])
`endif
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(17)) u17 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready[2]),
    .sum(sum), .a(a),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .diff(diff[2]), .borrow(borrow[2]), .ovf(ovf[2])
`ifdef SERIAL_SUB_ERRCNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt[2])
`endif
  );

  // Scoreboard: pop and compare on each output handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   emp;
    for (int i = 0; i < 3; i++) begin
      if (!rst && out_valid[i] && out_ready) begin
        emp = 1'b0;
        e   = '0;
        case (i)
          0: if (q0.size() == 0) emp = 1'b1; else e = q0.pop_front();
          1: if (q1.size() == 0) emp = 1'b1; else e = q1.pop_front();
          default: if (q2.size() == 0) emp = 1'b1; else e = q2.pop_front();
        endcase
        if (emp) begin
          ntot++;
          $display("FAIL unexpected_out[%0d]: got diff %h want no output", i, diff[i]);
        end else begin
          ntot += 3;
          if (diff[i] !== e.d)
            $display("FAIL diff[%0d]: got %h want %h", i, diff[i], e.d);
          else npass++;
          if (borrow[i] !== e.b)
            $display("FAIL borrow[%0d]: got %b want %b", i, borrow[i], e.b);
          else npass++;
          if (ovf[i] !== e.o)
            $display("FAIL ovf[%0d]: got %b want %b", i, ovf[i], e.o);
          else npass++;
        end
      end
    end
  end

  task automatic start_op(input logic [16:0] s, input logic [15:0] av,
                          input logic [15:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.d = ed;
    e.b = eb;
    e.o = eo;
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
    sum = s;
    a = av;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0
             && in_ready[0] && in_ready[1] && in_ready[2]
             && !out_valid[0] && !out_valid[1] && !out_valid[2])
           && n < maxc) begin
      @(negedge clk);
      n++;
    end
    ntot++;
    if (n >= maxc)
      $display("FAIL idle_timeout: got %0d cycles want < %0d", n, maxc);
    else npass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ntot += 5;
    if (in_ready[0] !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready[0]);
    else npass++;
    if (out_valid[0] !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid[0]);
    else npass++;
    if (diff[0] !== 16'h0) $display("FAIL rst_diff: got %h want 0000", diff[0]);
    else npass++;
    if (borrow[0] !== 1'b0) $display("FAIL rst_borrow: got %b want 0", borrow[0]);
    else npass++;
    if (ovf[0] !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf[0]);
    else npass++;
`ifdef SERIAL_SUB_ERRCNT_EN
    ntot++;
    if (err_cnt[0] !== 16'h0) $display("FAIL rst_err_cnt: got %h want 0000", err_cnt[0]);
    else npass++;
`endif
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    start_op(17'h0_1234, 16'h0034, 16'h1200, 1'b0, 1'b0);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      ntot++;
      if (out_valid[0] !== (j == 5))
        $display("FAIL latency_%0d: got %b want %b", j, out_valid[0], (j == 5));
      else npass++;
    end
    wait_idle(60);
  endtask

  task automatic test_overflow;
    start_op(17'h1_0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_idle(60);
    start_op(17'h1_FFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    wait_idle(60);
`ifdef SERIAL_SUB_ERRCNT_EN
    ntot++;
    if (err_cnt[0] !== 16'd2) $display("FAIL ovf_err_cnt: got %0d want 2", err_cnt[0]);
    else npass++;
`endif
  endtask

  task automatic test_underflow;
`ifdef SERIAL_SUB_ERRCNT_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
`endif
    start_op(17'h0_0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0);
    wait_idle(60);
`ifdef SERIAL_SUB_ERRCNT_EN
    ntot++;
    if (err_cnt[0] !== 16'd1) $display("FAIL udf_err_cnt: got %0d want 1", err_cnt[0]);
    else npass++;
`endif
  endtask

  task automatic test_backpressure;
    int n = 0;
    out_ready = 1'b0;
    start_op(17'h0_0300, 16'h0100, 16'h0200, 1'b0, 1'b0);
    while (!(out_valid[0] && out_valid[1] && out_valid[2]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    ntot++;
    if (n >= 60) $display("FAIL bp_done_timeout: got %0d cycles want < 60", n);
    else npass++;
    sum = 17'h1_FFFF;
    a = 16'h0000;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ntot += 3;
      if (out_valid[0] !== 1'b1) $display("FAIL bp_valid_%0d: got %b want 1", k, out_valid[0]);
      else npass++;
      if (diff[0] !== 16'h0200) $display("FAIL bp_diff_%0d: got %h want 0200", k, diff[0]);
      else npass++;
      if (in_ready[0] !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready[0]);
      else npass++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ntot += 3;
    if (out_valid[0] !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid[0]);
    else npass++;
    if (in_ready[0] !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready[0]);
    else npass++;
    if (diff[0] !== 16'h0200) $display("FAIL bp_hold_diff: got %h want 0200", diff[0]);
    else npass++;
    wait_idle(60);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    start_op(17'h0_FFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ntot += 4;
    if (in_ready[0] !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready[0]);
    else npass++;
    if (out_valid[0] !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid[0]);
    else npass++;
    if (diff[0] !== 16'h0000) $display("FAIL mid_diff: got %h want 0000", diff[0]);
    else npass++;
    if (in_ready[1] !== 1'b1) $display("FAIL mid_in_ready_d1: got %b want 1", in_ready[1]);
    else npass++;
    q0.delete();
    q1.delete();
    start_op(17'h0_00FF, 16'h000F, 16'h00F0, 1'b0, 1'b0);
    wait_idle(60);
  endtask

  task automatic test_random;
    logic [15:0] av;
    logic [15:0] bv;
    logic [16:0] s;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      av = 16'($urandom_range(0, 65535));
      bv = 16'($urandom_range(0, 65535));
      s  = {1'b0, av} + {1'b0, bv};
      start_op(s, av, bv, 1'b0, 1'b0);
      wait_idle(60);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
